// File: rtl/regs_wb_sched.sv
// Write-back scheduler and scoreboard for the 32x32 register file: arbitrates the
// single write port between the ALU and a long-latency unit and stalls ID on hazards.
module regs_wb_sched #(
    parameter int XLEN       = 32,
    parameter int MAX_STARVE = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [4:0]      id_rs1_addr,
    input  logic [4:0]      id_rs2_addr,
    input  logic [4:0]      id_rd_addr,
    input  logic            id_rd_wen,
    input  logic            id_issue_long,
    output logic            hazard_stall,
    input  logic            alu_wen,
    input  logic [4:0]      alu_rd_addr,
    input  logic [XLEN-1:0] alu_rd_data,
    output logic            alu_ready,
    input  logic            long_valid,
    input  logic [4:0]      long_rd_addr,
    input  logic [XLEN-1:0] long_rd_data,
    output logic            long_ready,
    output logic            rd_wen,
    output logic [4:0]      rd_forward_addr,
    output logic [XLEN-1:0] rd_forward_data
);

    localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);

    logic [31:0]     busy_r;
    logic [3:0]      starve_cnt_r;
    logic            rd_wen_r;
    logic [4:0]      rd_addr_r;
    logic [XLEN-1:0] rd_data_r;

    logic            hazard_s;
    logic            alu_req_s;
    logic            pre_s;
    logic            long_ready_s;
    logic            alu_ready_s;
    logic            alu_grant_s;
    logic            long_grant_s;
    logic            set_s;
    logic [31:0]     busy_next_s;

    // Hazard detection against the pre-edge scoreboard
    always_comb begin
        hazard_s = 1'b0;
        if (id_valid) begin
            hazard_s = ((id_rs1_addr != 5'd0) && busy_r[id_rs1_addr]) ||
                       ((id_rs2_addr != 5'd0) && busy_r[id_rs2_addr]) ||
                       (id_rd_wen && (id_rd_addr != 5'd0) && busy_r[id_rd_addr]);
        end else begin
            hazard_s = 1'b0;
        end
    end

    // Write-port arbitration; a starved long unit pre-empts the ALU
    always_comb begin
        alu_req_s    = alu_wen & (alu_rd_addr != 5'd0);
        pre_s        = long_valid & (starve_cnt_r == STARVE_MAX);
        long_ready_s = ~alu_req_s | pre_s;
        alu_ready_s  = ~pre_s;
        alu_grant_s  = alu_req_s & alu_ready_s;
        long_grant_s = long_valid & long_ready_s;
        set_s        = id_valid & ~hazard_s & id_issue_long & id_rd_wen &
                       (id_rd_addr != 5'd0);
    end

    // Next scoreboard: set and clear never collide since a busy rd stalls
    always_comb begin
        busy_next_s = busy_r;
        if (long_grant_s) begin
            busy_next_s[long_rd_addr] = 1'b0;
        end else begin
            busy_next_s = busy_r;
        end
        if (set_s) begin
            busy_next_s[id_rd_addr] = 1'b1;
        end else begin
            busy_next_s[0] = 1'b0;
        end
        busy_next_s[0] = 1'b0;
    end

    // Scoreboard and starvation counter state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r       <= 32'd0;
            starve_cnt_r <= 4'd0;
        end else begin
            busy_r <= busy_next_s;
            if (!long_valid || long_grant_s) begin
                starve_cnt_r <= 4'd0;
            end else if (starve_cnt_r != STARVE_MAX) begin
                starve_cnt_r <= starve_cnt_r + 4'd1;
            end
        end
    end

    // Registered write-back stage feeding the regfile write/forward port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_wen_r  <= 1'b0;
            rd_addr_r <= 5'd0;
            rd_data_r <= '0;
        end else if (alu_grant_s) begin
            rd_wen_r  <= 1'b1;
            rd_addr_r <= alu_rd_addr;
            rd_data_r <= alu_rd_data;
        end else if (long_grant_s) begin
            rd_wen_r  <= (long_rd_addr != 5'd0);
            rd_addr_r <= long_rd_addr;
            rd_data_r <= long_rd_data;
        end else begin
            rd_wen_r  <= 1'b0;
        end
    end

    assign hazard_stall    = hazard_s;
    assign alu_ready       = alu_ready_s;
    assign long_ready      = long_ready_s;
    assign rd_wen          = rd_wen_r;
    assign rd_forward_addr = rd_addr_r;
    assign rd_forward_data = rd_data_r;

endmodule

// File: tb/tb_regs_wb_sched.sv
// Directed self-checking bench for regs_wb_sched with hand-computed expectations.
module tb_regs_wb_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic        id_rd_wen, id_issue_long;
    logic        hazard_stall;
    logic        alu_wen;
    logic [4:0]  alu_rd_addr;
    logic [31:0] alu_rd_data;
    logic        alu_ready;
    logic        long_valid;
    logic [4:0]  long_rd_addr;
    logic [31:0] long_rd_data;
    logic        long_ready;
    logic        rd_wen;
    logic [4:0]  rd_forward_addr;
    logic [31:0] rd_forward_data;

    int checks = 0;
    int failures = 0;

    regs_wb_sched #(.XLEN(32), .MAX_STARVE(3)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rd_addr(id_rd_addr), .id_rd_wen(id_rd_wen), .id_issue_long(id_issue_long),
        .hazard_stall(hazard_stall),
        .alu_wen(alu_wen), .alu_rd_addr(alu_rd_addr), .alu_rd_data(alu_rd_data),
        .alu_ready(alu_ready),
        .long_valid(long_valid), .long_rd_addr(long_rd_addr), .long_rd_data(long_rd_data),
        .long_ready(long_ready),
        .rd_wen(rd_wen), .rd_forward_addr(rd_forward_addr), .rd_forward_data(rd_forward_data)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id_set(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic wen, input logic lng);
        id_valid = v; id_rs1_addr = rs1; id_rs2_addr = rs2;
        id_rd_addr = rd; id_rd_wen = wen; id_issue_long = lng;
    endtask

    initial begin
        rst = 1'b0;
        id_set(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        alu_wen = 1'b0; alu_rd_addr = 5'd0; alu_rd_data = 32'd0;
        long_valid = 1'b0; long_rd_addr = 5'd0; long_rd_data = 32'd0;
        tick(); tick();
        check_eq("reset_rd_wen", {31'd0, rd_wen}, 32'd0);
        check_eq("reset_addr", {27'd0, rd_forward_addr}, 32'd0);
        check_eq("reset_data", rd_forward_data, 32'd0);
        rst = 1'b1;

        // 1: reset mid-operation
        id_set(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1);
        #1 check_eq("t1_issue_no_stall", {31'd0, hazard_stall}, 32'd0);
        tick();
        id_set(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
        #1 check_eq("t1_busy5_stall", {31'd0, hazard_stall}, 32'd1);
        id_set(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        alu_wen = 1'b1; alu_rd_addr = 5'd2; alu_rd_data = 32'h55;
        long_valid = 1'b1; long_rd_addr = 5'd5; long_rd_data = 32'h77;
        #1 check_eq("t1_long_refused", {31'd0, long_ready}, 32'd0);
        tick();
        check_eq("t1_pre_rst_wen", {31'd0, rd_wen}, 32'd1);
        rst = 1'b0;
        #1;
        check_eq("t1_rst_wen", {31'd0, rd_wen}, 32'd0);
        check_eq("t1_rst_addr", {27'd0, rd_forward_addr}, 32'd0);
        check_eq("t1_rst_data", rd_forward_data, 32'd0);
        alu_wen = 1'b0; long_valid = 1'b0;
        #1 rst = 1'b1;
        id_set(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
        #1 check_eq("t1_busy_cleared", {31'd0, hazard_stall}, 32'd0);
        tick();

        // 2: RAW stall until the long handshake on rd=7
        id_set(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1);
        #1 check_eq("t2_issue", {31'd0, hazard_stall}, 32'd0);
        tick();
        id_set(1'b1, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0);
        #1 check_eq("t2_raw_stall", {31'd0, hazard_stall}, 32'd1);
        tick();
        check_eq("t2_raw_stall_hold", {31'd0, hazard_stall}, 32'd1);
        long_valid = 1'b1; long_rd_addr = 5'd7; long_rd_data = 32'hDEADBEEF;
        #1;
        check_eq("t2_long_ready", {31'd0, long_ready}, 32'd1);
        check_eq("t2_stall_pre_edge", {31'd0, hazard_stall}, 32'd1);
        tick();
        long_valid = 1'b0;
        #1;
        check_eq("t2_wb_wen", {31'd0, rd_wen}, 32'd1);
        check_eq("t2_wb_addr", {27'd0, rd_forward_addr}, 32'd7);
        check_eq("t2_wb_data", rd_forward_data, 32'hDEADBEEF);
        check_eq("t2_released", {31'd0, hazard_stall}, 32'd0);
        id_set(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();

        // 3: WAW against busy[9]
        id_set(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1);
        tick();
        id_set(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0);
        #1 check_eq("t3_waw_stall", {31'd0, hazard_stall}, 32'd1);
        id_set(1'b1, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0);
        #1 check_eq("t3_no_wen_no_stall", {31'd0, hazard_stall}, 32'd0);
        id_set(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        long_valid = 1'b1; long_rd_addr = 5'd9; long_rd_data = 32'h99;
        tick();
        long_valid = 1'b0;
        id_set(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0);
        #1 check_eq("t3_cleared", {31'd0, hazard_stall}, 32'd0);
        id_set(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();

        // 4: collision, ALU wins with starve count at zero
        alu_wen = 1'b1; alu_rd_addr = 5'd3; alu_rd_data = 32'h11;
        long_valid = 1'b1; long_rd_addr = 5'd4; long_rd_data = 32'h22;
        #1;
        check_eq("t4_alu_ready", {31'd0, alu_ready}, 32'd1);
        check_eq("t4_long_ready", {31'd0, long_ready}, 32'd0);
        tick();
        check_eq("t4_wb_wen", {31'd0, rd_wen}, 32'd1);
        check_eq("t4_wb_addr", {27'd0, rd_forward_addr}, 32'd3);
        check_eq("t4_wb_data", rd_forward_data, 32'h11);

        // 5: starvation, pre-emption on the fourth contested cycle
        check_eq("t5_refused_2", {31'd0, long_ready}, 32'd0);
        tick();
        check_eq("t5_refused_3", {31'd0, long_ready}, 32'd0);
        tick();
        check_eq("t5_pre_long_ready", {31'd0, long_ready}, 32'd1);
        check_eq("t5_pre_alu_ready", {31'd0, alu_ready}, 32'd0);
        tick();
        long_valid = 1'b0;
        #1;
        check_eq("t5_long_addr", {27'd0, rd_forward_addr}, 32'd4);
        check_eq("t5_long_data", rd_forward_data, 32'h22);
        check_eq("t5_alu_ready_again", {31'd0, alu_ready}, 32'd1);
        tick();
        check_eq("t5_alu_next_addr", {27'd0, rd_forward_addr}, 32'd3);
        check_eq("t5_alu_next_data", rd_forward_data, 32'h11);

        // 6: x0 handling
        alu_rd_addr = 5'd0; alu_rd_data = 32'hAA;
        #1 check_eq("t6_alu_x0_ready", {31'd0, alu_ready}, 32'd1);
        tick();
        alu_wen = 1'b0;
        check_eq("t6_alu_x0_no_wen", {31'd0, rd_wen}, 32'd0);
        check_eq("t6_alu_x0_addr_hold", {27'd0, rd_forward_addr}, 32'd3);
        id_set(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        #1 check_eq("t6_issue_x0", {31'd0, hazard_stall}, 32'd0);
        tick();
        id_set(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        long_valid = 1'b1; long_rd_addr = 5'd0; long_rd_data = 32'h33;
        #1 check_eq("t6_long_x0_ready", {31'd0, long_ready}, 32'd1);
        tick();
        long_valid = 1'b0;
        check_eq("t6_long_x0_no_wen", {31'd0, rd_wen}, 32'd0);
        check_eq("t6_long_x0_data", rd_forward_data, 32'h33);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regs_wb_sched.md
Name: regs_wb_sched

Overview:
- Write-back scheduler and scoreboard in front of the 32x32 register file.
- Arbitrates the regfile's single write port between two requesters:
  - the single-cycle ALU path, which has normal priority;
  - a long-latency unit (load/div) using a valid/ready handshake.
- Registers the winning write onto the regfile's write/forward inputs.
- Tracks destination registers of in-flight long-latency ops and raises a stall to ID on RAW/WAW hazards.

Parameters:
XLEN, 32, data width
MAX_STARVE, 3, consecutive cycles the long unit may be refused before it pre-empts the ALU (1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
id_valid  in  1  ID holds a valid instruction this cycle
id_rs1_addr  in  5  ID source 1
id_rs2_addr  in  5  ID source 2
id_rd_addr  in  5  ID destination
id_rd_wen  in  1  ID instruction writes rd
id_issue_long  in  1  ID instruction goes to the long-latency unit
hazard_stall  out  1  hold ID/IF; instruction not issued
alu_wen  in  1  ALU write-back request
alu_rd_addr  in  5  ALU destination
alu_rd_data  in  XLEN  ALU result
alu_ready  out  1  ALU write accepted this cycle
long_valid  in  1  long unit result valid
long_rd_addr  in  5  long unit destination
long_rd_data  in  XLEN  long unit result
long_ready  out  1  long unit result accepted this cycle
rd_wen  out  1  to regfile write/forward enable
rd_forward_addr  out  5  to regfile
rd_forward_data  out  XLEN  to regfile

Behaviour:
- Reset (rst=0, asynchronous): rd_wen=0, rd_forward_addr=0, rd_forward_data=0, busy[31:0]=0, starve_cnt=0. In-flight long ops are forgotten.
- Scoreboard busy[31:1] is registered; busy[0] is always 0.
- hazard_stall is combinational from current busy and ID inputs. It is 1 when id_valid and any of:
  - rs1!=0 and busy[rs1];
  - rs2!=0 and busy[rs2];
  - id_rd_wen and rd!=0 and busy[rd].
- Issue = id_valid & !hazard_stall.
- Set: issue & id_issue_long & id_rd_wen & rd!=0 sets busy[rd] at the next edge.
- Clear: long handshake (long_valid & long_ready) clears busy[long_rd_addr] at the next edge.
- Set and clear in the same cycle always target different registers, because a busy rd stalls. Both take effect.
- Stall uses pre-edge busy, so a register cleared this cycle still stalls for this cycle. Fixed one-bubble penalty.
- Request qualification:
  - alu_req = alu_wen & alu_rd_addr!=0.
  - alu_wen with rd=0 is acknowledged (alu_ready=1) and discarded.
  - A long result with rd=0 is accepted when granted and discarded (no rd_wen).
- Arbitration is combinational. pre = long_valid & (starve_cnt==MAX_STARVE).
  - long_ready = !alu_req | pre
  - alu_ready = !pre
- Write-back grant:
  - ALU grant: alu_req & alu_ready.
  - Long grant: long_valid & long_ready.
  - At most one grant per cycle.
- starve_cnt:
  - Increments when long_valid & !long_ready, saturating at MAX_STARVE.
  - Cleared on a long handshake and when !long_valid.
- Requester rules:
  - The long unit must hold long_valid and its payload stable until long_ready.
  - The ALU stage holds when alu_ready=0.
- Output stage, one cycle latency from grant:
  - At the next edge rd_wen <= grant & granted rd!=0.
  - rd_forward_addr/rd_forward_data <= the winner's addr/data.
  - With no grant: rd_wen<=0 and addr/data hold their last value.
  - The regfile forwards rd_forward_data combinationally in that cycle, so a consumer released by a busy clear sees the correct value.
- No flush input. Reset is the only way to drop scoreboard state.

Test Plan:
1. Reset mid-operation: busy[5]=1, long result pending, assert rst=0 -> all outputs 0, busy cleared, hazard_stall=0 for id_rs1=5 after release.
2. RAW stall: issue long op rd=7, then ID rs2=7 -> hazard_stall=1 until the long handshake on rd=7 (data 0xDEADBEEF). Next cycle rd_wen=1, addr=7, data=0xDEADBEEF, hazard_stall=0.
3. WAW: busy[9]=1, ID ALU op rd=9 id_rd_wen=1 -> hazard_stall=1. The same op with id_rd_wen=0 -> hazard_stall=0.
4. Collision: alu_wen rd=3 data=0x11 and long_valid rd=4 data=0x22 together, starve_cnt=0 -> alu_ready=1, long_ready=0. Next cycle rd_wen=1, addr=3, data=0x11.
5. Starvation, MAX_STARVE=3: alu_wen held every cycle, long_valid held -> long_ready=0 for 3 cycles, then long_ready=1, alu_ready=0. Next cycle addr=4, data=0x22. ALU wins the following cycle.
6. x0 handling: alu_wen rd=0 -> alu_ready=1, rd_wen stays 0. Issue long rd=0 -> no busy bit set. Its result is accepted with no rd_wen.
